// File: rtl/mux_arb_n_pkg.sv
// mux_arb_n_pkg: shared constants and helpers for the mux_arb_n selector.
//   MODE_FIXED / MODE_RR : values of the mode input.
//   wrap_add()           : modular add for indices when the channel count
//                          need not be a power of two.
package mux_arb_n_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // (a + b) mod n, valid when both a and b are already in 0..n-1.
  function automatic int wrap_add(input int a, input int b, input int n);
    int sum_v;
    sum_v = a + b;
    return (sum_v >= n) ? (sum_v - n) : sum_v;
  endfunction

endpackage

// File: rtl/mux_arb_n_if.sv
// mux_arb_n_if: handshake/data bundle between the sources, the selector and
// the downstream consumer.
//   in_data  : flat input bus, channel i at [i*WIDTH +: WIDTH]
//   in_valid : per-channel request
//   in_ready : per-channel accept (one-hot or zero)
//   o        : held output data
//   o_ch     : channel index the held data came from
//   o_valid  : output register holds data
//   o_ready  : downstream consumes when o_valid && o_ready
// slave  = the selector's view, master = the environment's view.
interface mux_arb_n_if #(
  parameter int WIDTH = 5,
  parameter int NCH   = 4,
  parameter int SELW  = 2
);

  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [WIDTH-1:0]     o;
  logic [SELW-1:0]      o_ch;
  logic                 o_valid;
  logic                 o_ready;

  modport slave (
    input  in_data, in_valid, o_ready,
    output in_ready, o, o_ch, o_valid
  );

  modport master (
    output in_data, in_valid, o_ready,
    input  in_ready, o, o_ch, o_valid
  );

endinterface

// File: rtl/mux_arb_n_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req     : per-channel request vector
//   ptr     : channel with highest priority this evaluation (0..NCH-1)
//   gnt_idx : first requesting channel at or after ptr, wrapping at NCH
//   gnt_vld : at least one channel is requesting
module rr_pick
  import mux_arb_n_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int SELW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  int   off_v;
  int   best_v;
  logic take_v;

  // Each channel's distance from ptr (mod NCH) is its priority; the smallest
  // distance among requesters wins. Indexing by the constant loop variable
  // keeps the request select free of run-time indices.
  always_comb begin
    gnt_idx = {SELW{1'b0}};
    gnt_vld = 1'b0;
    best_v  = NCH;
    off_v   = 0;
    take_v  = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      off_v   = wrap_add(i, NCH - int'(ptr), NCH);
      take_v  = req[i] && (off_v < best_v);
      best_v  = take_v ? off_v : best_v;
      gnt_idx = take_v ? SELW'(i) : gnt_idx;
      gnt_vld = gnt_vld | take_v;
    end
  end

endmodule

// File: rtl/mux_arb_n.sv
// mux_arb_n: N-channel registered selector with valid/ready handshake.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   mode : MODE_FIXED selects channel s, MODE_RR arbitrates round-robin
//   s    : channel select for fixed mode (out-of-range never grants)
//   bus  : mux_arb_n_if.slave carrying inputs, accepts and the one-entry
//          output register (o, o_ch, o_valid) with its o_ready consume.
module mux_arb_n
  import mux_arb_n_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode,
  input  logic [SELW-1:0] s,
  mux_arb_n_if.slave      bus
);

  logic [SELW-1:0]  ptr_r;
  logic [SELW-1:0]  ptr_nxt_s;
  logic [SELW-1:0]  rr_idx_s;
  logic             rr_vld_s;
  logic             fix_vld_s;
  logic [SELW-1:0]  gnt_idx_s;
  logic             gnt_vld_s;
  logic             load_s;
  logic [NCH-1:0]   in_ready_s;
  logic [WIDTH-1:0] gnt_data_s;
  logic [WIDTH-1:0] o_r;
  logic [SELW-1:0]  o_ch_r;
  logic             o_valid_r;

  rr_pick #(
    .NCH  (NCH),
    .SELW (SELW)
  ) u_rr_pick (
    .req     (bus.in_valid),
    .ptr     (ptr_r),
    .gnt_idx (rr_idx_s),
    .gnt_vld (rr_vld_s)
  );

  // Fixed-mode request: only channel s counts; an s beyond NCH-1 matches
  // no channel and so never grants.
  always_comb begin
    fix_vld_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      fix_vld_s = fix_vld_s | ((s == SELW'(i)) & bus.in_valid[i]);
    end
  end

  // Grant source by mode, then the load decision and per-channel accepts.
  // Reset gates load so no source sees an accept while the register is
  // being cleared.
  always_comb begin
    gnt_idx_s  = {SELW{1'b0}};
    gnt_vld_s  = 1'b0;
    in_ready_s = {NCH{1'b0}};
    if (mode == MODE_RR) begin
      gnt_idx_s = rr_idx_s;
      gnt_vld_s = rr_vld_s;
    end else begin
      gnt_idx_s = s;
      gnt_vld_s = fix_vld_s;
    end
    load_s = !rst && (!o_valid_r || bus.o_ready) && gnt_vld_s;
    for (int i = 0; i < NCH; i++) begin
      in_ready_s[i] = load_s && (gnt_idx_s == SELW'(i));
    end
  end

  // Data of the granted channel and the post-grant pointer (explicit wrap).
  always_comb begin
    gnt_data_s = {WIDTH{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      gnt_data_s = (gnt_idx_s == SELW'(i)) ? bus.in_data[i*WIDTH +: WIDTH]
                                           : gnt_data_s;
    end
    ptr_nxt_s = SELW'(wrap_add(int'(gnt_idx_s), 1, NCH));
  end

  // One-entry output register: load replaces (even while being consumed),
  // a bare consume only drops valid, otherwise everything holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_r       <= {WIDTH{1'b0}};
      o_ch_r    <= {SELW{1'b0}};
      o_valid_r <= 1'b0;
    end else if (load_s) begin
      o_r       <= gnt_data_s;
      o_ch_r    <= gnt_idx_s;
      o_valid_r <= 1'b1;
    end else if (o_valid_r && bus.o_ready) begin
      o_r       <= o_r;
      o_ch_r    <= o_ch_r;
      o_valid_r <= 1'b0;
    end else begin
      o_r       <= o_r;
      o_ch_r    <= o_ch_r;
      o_valid_r <= o_valid_r;
    end
  end

  // Rotation pointer advances only on round-robin loads; fixed mode and
  // mode switches leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= {SELW{1'b0}};
    end else if (load_s && (mode == MODE_RR)) begin
      ptr_r <= ptr_nxt_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.o        = o_r;
  assign bus.o_ch     = o_ch_r;
  assign bus.o_valid  = o_valid_r;

endmodule
